change_payout: RTL

Change-dispensing sequencer that sits directly downstream of the vending datapath. It latches the coin counts the datapath computes for a transaction ($1 count, $0.50 bit, $0.25 bit) and drives the coin-hopper solenoids one coin at a time. Each dispensed coin must be confirmed by the drop sensor before the block moves on. It reports remaining owed value, completion, and a sticky fault on a jammed or empty hopper.

---
 rtl/change_payout_if.sv | 45 ++++
 rtl/change_payout.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/change_payout_if.sv
// change_payout_if
// Bundles the request, hopper-status, drop-sensor and status signals that pass
// between the vending datapath (master) and the change_payout sequencer (slave).
//   in_load           one-cycle strobe: latch a new payout request
//   in_change_1       number of $1 coins to pay (8 bits)
//   in_change_05      pay one $0.50 coin
//   in_change_025     pay one $0.25 coin
//   in_empty_*        hopper-empty level per denomination
//   in_coin_sense     drop-sensor level; a rising edge confirms one coin
//   out_busy          request in progress (SELECT..DONE, and FAULT)
//   out_fire_*        registered solenoid drive, at most one high
//   out_owed          remaining value in datapath units ($1=8, $0.50=4, $0.25=2)
//   out_done          one-cycle completion pulse
//   out_fault         sticky jam / empty-hopper fault
interface change_payout_if;
  logic        in_load;
  logic [7:0]  in_change_1;
  logic        in_change_05;
  logic        in_change_025;
  logic        in_empty_1;
  logic        in_empty_05;
  logic        in_empty_025;
  logic        in_coin_sense;
  logic        out_busy;
  logic        out_fire_1;
  logic        out_fire_05;
  logic        out_fire_025;
  logic [15:0] out_owed;
  logic        out_done;
  logic        out_fault;

  modport master (
    output in_load, in_change_1, in_change_05, in_change_025,
           in_empty_1, in_empty_05, in_empty_025, in_coin_sense,
    input  out_busy, out_fire_1, out_fire_05, out_fire_025,
           out_owed, out_done, out_fault
  );

  modport slave (
    input  in_load, in_change_1, in_change_05, in_change_025,
           in_empty_1, in_empty_05, in_empty_025, in_coin_sense,
    output out_busy, out_fire_1, out_fire_05, out_fire_025,
           out_owed, out_done, out_fault
  );
endinterface

// File: rtl/change_payout.sv
// change_payout
// Change-dispensing sequencer. Latches the coin counts for one transaction and
// drives the hopper solenoids one coin at a time ($1 first, then $0.50, then
// $0.25). Each coin must be confirmed by a rising edge of the drop sensor before
// the next is fired; a missing confirmation or an empty hopper raises a sticky
// fault that only in_restart clears.
// Ports:
//   in_clka     clock, rising edge
//   in_restart  synchronous active-high reset
//   bus         change_payout_if.slave (request, hopper status, sensor, status)
// Parameters:
//   PULSE_CYCLES    solenoid on-time per coin (>=1)
//   GAP_CYCLES      quiet time between coins (>=1)
//   TIMEOUT_CYCLES  max cycles from solenoid rise to sensor edge (> PULSE_CYCLES)
module change_payout #(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic           in_clka,
  input  logic           in_restart,
  change_payout_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SELECT, FIRE, WAIT, GAP, DONE, FAULT
  } state_t;

  typedef enum logic [1:0] {
    DEN_NONE, DEN_1, DEN_05, DEN_025
  } den_t;

  localparam logic [15:0] PULSE_LAST   = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  den_t        sel, pick, den_next;
  logic        pick_empty;
  logic [7:0]  cnt_1;
  logic        cnt_05, cnt_025;
  logic [15:0] owed;
  logic [15:0] tmr;
  logic        sensed;
  logic        sense_p0, sense_p1;
  logic        coin_edge, coin_hit;
  logic        fire_1, fire_05, fire_025;

  function automatic logic [15:0] coin_value(input den_t d);
    case (d)
      DEN_1:   coin_value = 16'd8;
      DEN_05:  coin_value = 16'd4;
      DEN_025: coin_value = 16'd2;
      default: coin_value = 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] request_value(input logic [7:0] n1,
                                                input logic n05,
                                                input logic n025);
    request_value = {5'd0, n1, 3'd0} + {13'd0, n05, 2'd0} + {14'd0, n025, 1'b0};
  endfunction

  // Priority pick of the next denomination to pay and its hopper status.
  always_comb begin
    pick       = DEN_NONE;
    pick_empty = 1'b0;
    if (cnt_1 != 8'd0) begin
      pick       = DEN_1;
      pick_empty = bus.in_empty_1;
    end else if (cnt_05) begin
      pick       = DEN_05;
      pick_empty = bus.in_empty_05;
    end else if (cnt_025) begin
      pick       = DEN_025;
      pick_empty = bus.in_empty_025;
    end
  end

  // Sensor stage p1: edge detect on the registered sensor; only the first edge
  // per coin while the solenoid is active (FIRE) or awaited (WAIT) counts.
  assign coin_edge = sense_p0 & ~sense_p1;
  assign coin_hit  = coin_edge & ~sensed & ((state == FIRE) | (state == WAIT));

  // FIRE is only ever entered from SELECT, so the fire outputs can be
  // registered from the denomination SELECT is about to commit.
  assign den_next = (state == SELECT) ? pick : sel;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (bus.in_load) state_next = SELECT;
      SELECT: begin
        if (pick == DEN_NONE)  state_next = DONE;
        else if (pick_empty)   state_next = FAULT;
        else                   state_next = FIRE;
      end
      FIRE:   if (tmr == PULSE_LAST) state_next = (sensed | coin_hit) ? GAP : WAIT;
      WAIT: begin
        if (coin_hit)                 state_next = GAP;
        else if (tmr == TIMEOUT_LAST) state_next = FAULT;
      end
      GAP:    if (tmr == GAP_LAST) state_next = SELECT;
      DONE:   state_next = IDLE;
      FAULT:  state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      state    <= IDLE;
      sel      <= DEN_NONE;
      cnt_1    <= 8'd0;
      cnt_05   <= 1'b0;
      cnt_025  <= 1'b0;
      owed     <= 16'd0;
      tmr      <= 16'd0;
      sensed   <= 1'b0;
      sense_p0 <= 1'b0;
      sense_p1 <= 1'b0;
      fire_1   <= 1'b0;
      fire_05  <= 1'b0;
      fire_025 <= 1'b0;
    end else begin
      state <= state_next;

      // Sensor stage p0 -> p1
      sense_p0 <= bus.in_coin_sense;
      sense_p1 <= sense_p0;

      fire_1   <= (state_next == FIRE) && (den_next == DEN_1);
      fire_05  <= (state_next == FIRE) && (den_next == DEN_05);
      fire_025 <= (state_next == FIRE) && (den_next == DEN_025);

      // One timer serves the pulse, the timeout and the gap: it restarts at
      // FIRE entry and keeps running through WAIT so the timeout is measured
      // from the solenoid rise; it restarts again at GAP entry.
      if ((state == SELECT) ||
          (((state == FIRE) || (state == WAIT)) && (state_next == GAP)))
        tmr <= 16'd0;
      else if ((state == FIRE) || (state == WAIT) || (state == GAP))
        tmr <= tmr + 16'd1;

      if (state == SELECT) begin
        sel    <= pick;
        sensed <= 1'b0;
      end

      if ((state == IDLE) && bus.in_load) begin
        cnt_1   <= bus.in_change_1;
        cnt_05  <= bus.in_change_05;
        cnt_025 <= bus.in_change_025;
        owed    <= request_value(bus.in_change_1, bus.in_change_05, bus.in_change_025);
      end

      if (coin_hit) begin
        sensed <= 1'b1;
        owed   <= owed - coin_value(sel);
        case (sel)
          DEN_1:   cnt_1   <= cnt_1 - 8'd1;
          DEN_05:  cnt_05  <= 1'b0;
          DEN_025: cnt_025 <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign bus.out_busy     = (state != IDLE);
  assign bus.out_done     = (state == DONE);
  assign bus.out_fault    = (state == FAULT);
  assign bus.out_owed     = owed;
  assign bus.out_fire_1   = fire_1;
  assign bus.out_fire_05  = fire_05;
  assign bus.out_fire_025 = fire_025;

endmodule
